id_issue_queue: RTL and testbench
=================================

Name: id_issue_queue

Overview:
- Elastic buffer between the decode stage and the issue stage.
- Decouples the decode valid/ack handshake from issue-side backpressure caused by scoreboard-full, FU-busy and accelerator stalls.
- Stores decoded scoreboard entries plus original instruction bits and control-flow flag, presented in order.
- Also supplies the previously issued entry (decoded_instr_i_prev at the issue stage).

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; uses NrIssuePorts (must be 1 for this block) and TRANS_ID_BITS.
- scoreboard_entry_t, logic, decoded instruction type.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk_i  in  1  subsystem clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  drop all queued entries and clear the prev entry
- decoded_instr_i  in  scoreboard_entry_t  entry from decode
- orig_instr_i  in  32  raw instruction bits
- is_ctrl_flow_i  in  1  entry is a control-flow instruction
- decoded_instr_valid_i  in  1  decode offers an entry
- decoded_instr_ack_o  out  1  entry accepted this cycle
- issue_instr_o  out  scoreboard_entry_t  head entry
- issue_instr_prev_o  out  scoreboard_entry_t  last entry acknowledged by issue
- orig_instr_o  out  32  head raw bits
- is_ctrl_flow_o  out  1  head control-flow flag
- issue_instr_valid_o  out  1  head valid
- issue_ack_i  in  1  issue consumed the head
- usage_o  out  $clog2(DEPTH)+1  current occupancy
- full_o  out  1  occupancy == DEPTH

Behaviour:
- Storage: circular buffer with read pointer, write pointer ($clog2(DEPTH) bits, natural wrap) and occupancy counter ($clog2(DEPTH)+1 bits).
- Reset: pointers, counter and prev register go to 0; all outputs 0. issue_instr_prev_o = '0.
- Push and ack: push = decoded_instr_valid_i & !full & !flush_i. decoded_instr_ack_o = push. The ack is combinational in valid and flush only; it never depends on issue_ack_i.
- Pop: pop = issue_ack_i & issue_instr_valid_o & !flush_i. issue_ack_i while not valid is ignored.
- Output: issue_instr_valid_o = (usage != 0). Head outputs are driven from mem[rd_ptr]. Head fields are stable while valid and not acked. Their values while not valid are don't-care but must be X-free after reset, so memory is reset to 0.
- Latency: 1 cycle; a pushed entry becomes visible on the cycle after the push.
- Simultaneous push and pop: counter unchanged, both pointers advance. At full, no push occurs even if pop is asserted (no same-cycle reuse).
- Prev register: on pop, prev <= head entry. It holds otherwise. On flush it is cleared to 0.
- Flush: on the next edge, pointers and counter go to 0 and prev is cleared. Push and pop in the flush cycle are suppressed, and valid is low the cycle after.
- Wrap-around: pointers wrap modulo DEPTH. FIFO order is preserved across the wrap.
- Reset mid-operation: asynchronous clear to the reset state regardless of the handshake in progress.

Optional Feature:
- Macro: ID_ISSUE_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty and decoded_instr_valid_i & !flush_i, the input is forwarded combinationally to the issue outputs with issue_instr_valid_o = 1 (0-cycle latency).
  - If issue_ack_i is also high that cycle, the entry is consumed without being written, and prev updates to it.
  - Otherwise it is written normally.
- Undefined: no bypass; valid is registered only; minimum latency 1 cycle.

Decomposition:
- Shared package: none new; scoreboard_entry_t comes from the core type set.
- Package addition to ariane_pkg: localparam helper for the pointer width ($clog2(DEPTH)).
- Sub-module: id_issue_queue_ctrl. Owns pointers, counter, full/empty and push/pop qualification. The top holds the payload memory and the prev register.

Test Plan:
- Reset, then 3 pushes (pc 0x100, 0x104, 0x108), issue_ack_i low -> usage_o = 3, issue_instr_o.pc = 0x100, valid = 1.
- Continue pushing to DEPTH = 4 -> full_o = 1; decoded_instr_ack_o = 0 with valid high; a 5th entry is held at decode with no loss.
- Ack every cycle over 10 entries across the pointer wrap -> pcs emerge in order; issue_instr_prev_o equals the previously acked pc each cycle.
- Simultaneous push and ack at usage 2 -> usage stays 2; head advances.
- flush_i with usage 3 and a push pending -> ack = 0 that cycle; next cycle usage 0, valid 0, prev = 0.
- Bypass enabled, empty queue, push pc 0x200 with issue_ack_i = 1 -> valid same cycle, usage stays 0, prev pc = 0x200 next cycle; bypass disabled -> valid appears one cycle later.

Source files
------------

// File: rtl/id_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// id_issue_queue_pkg
//   Types and helpers shared by the decode/issue elastic buffer.
//   - cva6_cfg_t / cva6_cfg_empty : reduced core configuration (only the
//     fields this block looks at).
//   - sb_entry_t                  : default decoded scoreboard entry.
//   - idq_ptr_w()                 : pointer width for a given queue depth.
// ---------------------------------------------------------------------------
package id_issue_queue_pkg;

    typedef struct packed {
        int unsigned NrIssuePorts;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrIssuePorts: 1, TRANS_ID_BITS: 3};

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  trans_id;
        logic [3:0]  fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        valid;
        logic        use_imm;
    } sb_entry_t;

    // Read/write pointer width; clamps at 1 so a degenerate depth still
    // elaborates (depth < 2 is rejected at elaboration by the top).
    function automatic int unsigned idq_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/id_issue_queue_ctrl.sv
// ---------------------------------------------------------------------------
// id_issue_queue_ctrl
//   Pointer / occupancy bookkeeping for id_issue_queue.
//   Optional feature macro: ID_ISSUE_QUEUE_BYPASS_EN (empty-queue bypass).
//   Ports:
//     clk_i, rst_ni   clock, async active-low reset
//     flush_i         clear pointers and counter on next edge
//     valid_i         decode offers an entry
//     issue_ack_i     issue consumes the presented head
//     ack_o           entry accepted from decode this cycle
//     wr_en_o         write the input into the payload memory at wr_ptr_o
//     pop_o           an entry was consumed by issue (prev must update)
//     bypass_o        the input is presented directly at the issue outputs
//     wr_ptr_o        write pointer
//     rd_ptr_o        read pointer (head)
//     usage_o         occupancy
//     full_o, empty_o occupancy flags
// ---------------------------------------------------------------------------
module id_issue_queue_ctrl
    import id_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = idq_ptr_w(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             issue_ack_i,
    output logic             ack_o,
    output logic             wr_en_o,
    output logic             pop_o,
    output logic             bypass_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] usage_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty, push, rd_en, byp_take;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // Decode-side accept never looks at issue_ack_i: at full a same-cycle
    // pop does not free a slot for the incoming entry.
    assign push  = valid_i & ~full & ~flush_i;
    assign rd_en = issue_ack_i & ~empty & ~flush_i;

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    assign bypass_o = empty & valid_i & ~flush_i;
`else
    assign bypass_o = 1'b0;
`endif

    // A bypassed entry acked in the same cycle never touches the memory.
    assign byp_take = bypass_o & issue_ack_i;
    assign wr_en_o  = push & ~byp_take;
    assign pop_o    = rd_en | byp_take;
    assign ack_o    = push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en_o, rd_en})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign usage_o  = cnt_q;
    assign full_o   = full;
    assign empty_o  = empty;

endmodule

// File: rtl/id_issue_queue.sv
// ---------------------------------------------------------------------------
// id_issue_queue
//   Elastic buffer between decode and issue. Holds decoded scoreboard
//   entries with their raw instruction bits and control-flow flag and
//   presents them in order; also exposes the last entry consumed by issue.
//   Optional feature macro: ID_ISSUE_QUEUE_BYPASS_EN -- when the queue is
//   empty the decode entry is forwarded to the issue outputs in the same
//   cycle.
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     flush_i                       drop queued entries, clear prev
//     decoded_instr_i / orig_instr_i / is_ctrl_flow_i / decoded_instr_valid_i
//                                   decode-side entry and valid
//     decoded_instr_ack_o           entry accepted
//     issue_instr_o / orig_instr_o / is_ctrl_flow_o / issue_instr_valid_o
//                                   head entry and valid
//     issue_instr_prev_o            last entry consumed by issue
//     issue_ack_i                   issue consumed the head
//     usage_o, full_o               occupancy and full flag
// ---------------------------------------------------------------------------
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg            = cva6_cfg_empty,
    parameter type         scoreboard_entry_t = sb_entry_t,
    parameter int unsigned DEPTH              = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  scoreboard_entry_t     decoded_instr_i,
    input  logic [31:0]           orig_instr_i,
    input  logic                  is_ctrl_flow_i,
    input  logic                  decoded_instr_valid_i,
    output logic                  decoded_instr_ack_o,
    output scoreboard_entry_t     issue_instr_o,
    output scoreboard_entry_t     issue_instr_prev_o,
    output logic [31:0]           orig_instr_o,
    output logic                  is_ctrl_flow_o,
    output logic                  issue_instr_valid_o,
    input  logic                  issue_ack_i,
    output logic [$clog2(DEPTH):0] usage_o,
    output logic                  full_o
);

    localparam int unsigned PTR_W = idq_ptr_w(DEPTH);

    if (CVA6Cfg.NrIssuePorts != 1) begin : g_bad_ports
        $error("id_issue_queue supports a single issue port only");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("id_issue_queue DEPTH must be a power of two >= 2");
    end

    logic             wr_en, pop, bypass, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    id_issue_queue_ctrl #(
        .DEPTH (DEPTH)
    ) i_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .valid_i     (decoded_instr_valid_i),
        .issue_ack_i (issue_ack_i),
        .ack_o       (decoded_instr_ack_o),
        .wr_en_o     (wr_en),
        .pop_o       (pop),
        .bypass_o    (bypass),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .usage_o     (usage_o),
        .full_o      (full_o),
        .empty_o     (empty)
    );

    // Payload memory is reset so the head outputs are X-free while empty.
    scoreboard_entry_t mem_q  [DEPTH];
    logic [31:0]       orig_q [DEPTH];
    logic [DEPTH-1:0]  cf_q;
    scoreboard_entry_t prev_q, prev_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]  <= '0;
                orig_q[i] <= '0;
            end
            cf_q <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr]  <= decoded_instr_i;
            orig_q[wr_ptr] <= orig_instr_i;
            cf_q[wr_ptr]   <= is_ctrl_flow_i;
        end
    end

    // Head mux: the bypass path only exists while the queue is empty, so
    // it never hides a stored entry.
    always_comb begin
        issue_instr_o  = mem_q[rd_ptr];
        orig_instr_o   = orig_q[rd_ptr];
        is_ctrl_flow_o = cf_q[rd_ptr];
        if (bypass) begin
            issue_instr_o  = decoded_instr_i;
            orig_instr_o   = orig_instr_i;
            is_ctrl_flow_o = is_ctrl_flow_i;
        end
    end

    assign issue_instr_valid_o = ~empty | bypass;

    // Whatever issue just consumed is exactly what the head mux presented.
    always_comb begin
        prev_d = prev_q;
        if (flush_i)  prev_d = '0;
        else if (pop) prev_d = issue_instr_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= '0;
        else         prev_q <= prev_d;
    end

    assign issue_instr_prev_o = prev_q;

endmodule

// File: tb/tb_id_issue_queue.sv
module tb_id_issue_queue;
    import id_issue_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        sb_entry_t   e;
        logic [31:0] orig;
        logic        cf;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    sb_entry_t   decoded_instr_i = '0;
    logic [31:0] orig_instr_i = '0;
    logic        is_ctrl_flow_i = 1'b0;
    logic        decoded_instr_valid_i = 1'b0;
    logic        decoded_instr_ack_o;
    sb_entry_t   issue_instr_o, issue_instr_prev_o;
    logic [31:0] orig_instr_o;
    logic        is_ctrl_flow_o, issue_instr_valid_o;
    logic        issue_ack_i = 1'b0;
    logic [$clog2(DEPTH):0] usage_o;
    logic        full_o;

    id_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .decoded_instr_i       (decoded_instr_i),
        .orig_instr_i          (orig_instr_i),
        .is_ctrl_flow_i        (is_ctrl_flow_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .issue_instr_o         (issue_instr_o),
        .issue_instr_prev_o    (issue_instr_prev_o),
        .orig_instr_o          (orig_instr_o),
        .is_ctrl_flow_o        (is_ctrl_flow_o),
        .issue_instr_valid_o   (issue_instr_valid_o),
        .issue_ack_i           (issue_ack_i),
        .usage_o               (usage_o),
        .full_o                (full_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a plain queue of accepted entries plus the last consumed one.
    item_t     mq[$];
    sb_entry_t mprev = '0;
    item_t     pend;

    // Expectations for the cycle currently driven
    bit        e_full, e_dack, e_byp, e_valid;
    item_t     e_head;
    int        e_usage;
    sb_entry_t e_prev;
    bit        cur_a, cur_f;
    item_t     cur_it;

    function automatic item_t mk(input logic [31:0] pc);
        item_t it;
        it.e    = {$urandom, $urandom, $urandom};
        it.e.pc = pc;
        it.orig = $urandom;
        it.cf   = 1'($urandom_range(0, 1));
        return it;
    endfunction

    // Drive one cycle's inputs and derive what the queue must show for it.
    task automatic drive(input bit v, input bit a, input bit f, input item_t it);
        @(negedge clk);
        decoded_instr_valid_i = v;
        issue_ack_i           = a;
        flush_i               = f;
        decoded_instr_i       = it.e;
        orig_instr_i          = it.orig;
        is_ctrl_flow_i        = it.cf;
        cur_a = a; cur_f = f; cur_it = it;
        #1;
        e_usage = mq.size();
        e_full  = (mq.size() == DEPTH);
        e_dack  = v && !e_full && !f;
        e_byp   = BYP && (mq.size() == 0) && v && !f;
        e_valid = (mq.size() != 0) || e_byp;
        e_head  = (mq.size() != 0) ? mq[0] : it;
        e_prev  = mprev;
    endtask

    // Advance the model across the clock edge.
    task automatic commit();
        bit popd;
        @(posedge clk);
        if (cur_f) begin
            mq.delete();
            mprev = '0;
        end else begin
            popd = cur_a && e_valid;
            if (popd) begin
                mprev = e_head.e;
                if (mq.size() != 0) void'(mq.pop_front());
            end
            if (e_dack && !(e_byp && popd)) mq.push_back(cur_it);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (usage_o !== '0) begin n_err++; $display("FAIL reset_usage: got %0d want 0", usage_o); end
        n_checks++; if (issue_instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", issue_instr_valid_o); end
        n_checks++; if (full_o !== 1'b0 || decoded_instr_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_flags: full %b ack %b want 0 0", full_o, decoded_instr_ack_o); end
        n_checks++; if (issue_instr_prev_o !== '0 || issue_instr_o !== '0 || orig_instr_o !== '0) begin n_err++; $display("FAIL reset_data: prev %h head %h want 0", issue_instr_prev_o, issue_instr_o); end
        rst_ni = 1'b1;
        mq.delete();
        mprev = '0;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, mk(32'h100 + 32'(4 * k)));
            n_checks++; if (decoded_instr_ack_o !== 1'b1) begin n_err++; $display("FAIL fill_ack: got %b want 1", decoded_instr_ack_o); end
            commit();
        end
        drive(0, 0, 0, mk(32'h0));
        n_checks++; if (usage_o !== 3) begin n_err++; $display("FAIL fill_usage3: got %0d want 3", usage_o); end
        n_checks++; if (issue_instr_valid_o !== 1'b1 || issue_instr_o.pc !== 32'h100) begin n_err++; $display("FAIL fill_head: valid %b pc %h want 1 100", issue_instr_valid_o, issue_instr_o.pc); end
        commit();
        drive(1, 0, 0, mk(32'h10c));
        commit();
        pend = mk(32'h110);
        drive(1, 0, 0, pend);
        n_checks++; if (full_o !== 1'b1 || usage_o !== 4) begin n_err++; $display("FAIL full_flag: full %b usage %0d want 1 4", full_o, usage_o); end
        n_checks++; if (decoded_instr_ack_o !== 1'b0) begin n_err++; $display("FAIL full_ack: got %b want 0", decoded_instr_ack_o); end
        commit();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc, last_pc;
        exp_pc  = 32'h100;
        last_pc = 32'h0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 0, pend);
            n_checks++; if (issue_instr_valid_o !== 1'b1 || issue_instr_o.pc !== exp_pc) begin n_err++; $display("FAIL wrap_order: valid %b pc %h want 1 %h", issue_instr_valid_o, issue_instr_o.pc, exp_pc); end
            n_checks++; if (issue_instr_prev_o.pc !== last_pc) begin n_err++; $display("FAIL wrap_prev: got %h want %h", issue_instr_prev_o.pc, last_pc); end
            n_checks++; if (orig_instr_o !== e_head.orig || is_ctrl_flow_o !== e_head.cf) begin n_err++; $display("FAIL wrap_payload: orig %h cf %b want %h %b", orig_instr_o, is_ctrl_flow_o, e_head.orig, e_head.cf); end
            commit();
            if (e_dack) pend = mk(pend.e.pc + 32'h4);
            last_pc = exp_pc;
            exp_pc  = exp_pc + 32'h4;
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] h;
        for (int k = 0; k < 2 * DEPTH && mq.size() > 2; k++) begin
            drive(0, 1, 0, pend);
            commit();
        end
        h = mq[0].e.pc;
        drive(1, 1, 0, pend);
        n_checks++; if (decoded_instr_ack_o !== 1'b1 || usage_o !== 2) begin n_err++; $display("FAIL pp_pre: ack %b usage %0d want 1 2", decoded_instr_ack_o, usage_o); end
        commit();
        if (e_dack) pend = mk(pend.e.pc + 32'h4);
        drive(0, 0, 0, pend);
        n_checks++; if (usage_o !== 2) begin n_err++; $display("FAIL pp_usage: got %0d want 2", usage_o); end
        n_checks++; if (issue_instr_o.pc !== h + 32'h4) begin n_err++; $display("FAIL pp_head: got %h want %h", issue_instr_o.pc, h + 32'h4); end
        commit();
    endtask

    task automatic test_flush();
        drive(1, 0, 0, pend);
        commit();
        if (e_dack) pend = mk(pend.e.pc + 32'h4);
        drive(1, 0, 1, pend);
        n_checks++; if (decoded_instr_ack_o !== 1'b0 || usage_o !== 3) begin n_err++; $display("FAIL flush_ack: ack %b usage %0d want 0 3", decoded_instr_ack_o, usage_o); end
        commit();
        drive(0, 0, 0, pend);
        n_checks++; if (usage_o !== 0 || issue_instr_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_empty: usage %0d valid %b want 0 0", usage_o, issue_instr_valid_o); end
        n_checks++; if (issue_instr_prev_o !== '0) begin n_err++; $display("FAIL flush_prev: got %h want 0", issue_instr_prev_o); end
        commit();
    endtask

    task automatic test_bypass();
        pend = mk(32'h200);
        drive(1, 1, 0, pend);
        n_checks++; if (decoded_instr_ack_o !== 1'b1) begin n_err++; $display("FAIL byp_ack: got %b want 1", decoded_instr_ack_o); end
        n_checks++; if (issue_instr_valid_o !== BYP) begin n_err++; $display("FAIL byp_valid0: got %b want %b", issue_instr_valid_o, BYP); end
        commit();
        drive(0, 0, 0, pend);
        if (BYP) begin
            n_checks++; if (usage_o !== 0 || issue_instr_prev_o.pc !== 32'h200) begin n_err++; $display("FAIL byp_take: usage %0d prev %h want 0 200", usage_o, issue_instr_prev_o.pc); end
            commit();
        end else begin
            n_checks++; if (issue_instr_valid_o !== 1'b1 || issue_instr_o.pc !== 32'h200 || usage_o !== 1) begin n_err++; $display("FAIL nobyp_late: valid %b pc %h usage %0d want 1 200 1", issue_instr_valid_o, issue_instr_o.pc, usage_o); end
            commit();
            drive(0, 1, 0, pend);
            commit();
            drive(0, 0, 0, pend);
            n_checks++; if (usage_o !== 0 || issue_instr_prev_o.pc !== 32'h200) begin n_err++; $display("FAIL nobyp_drain: usage %0d prev %h want 0 200", usage_o, issue_instr_prev_o.pc); end
            commit();
        end
    endtask

    task automatic test_random();
        bit v, a, f;
        pend = mk(32'h300);
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 99) < 70);
            a = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 99) < 4);
            drive(v, a, f, pend);
            n_checks++;
            if (decoded_instr_ack_o !== e_dack || issue_instr_valid_o !== e_valid ||
                usage_o !== e_usage[$clog2(DEPTH):0] || full_o !== e_full) begin
                n_err++;
                $display("FAIL rnd_ctrl cyc %0d: ack %b valid %b usage %0d full %b want %b %b %0d %b",
                         k, decoded_instr_ack_o, issue_instr_valid_o, usage_o, full_o, e_dack, e_valid, e_usage, e_full);
            end
            n_checks++;
            if (issue_instr_prev_o !== e_prev) begin n_err++; $display("FAIL rnd_prev cyc %0d: got %h want %h", k, issue_instr_prev_o, e_prev); end
            if (e_valid) begin
                n_checks++;
                if (issue_instr_o !== e_head.e || orig_instr_o !== e_head.orig || is_ctrl_flow_o !== e_head.cf) begin
                    n_err++;
                    $display("FAIL rnd_head cyc %0d: pc %h orig %h want pc %h orig %h", k, issue_instr_o.pc, orig_instr_o, e_head.e.pc, e_head.orig);
                end
            end
            commit();
            if (e_dack) pend = mk(pend.e.pc + 32'h4);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, mk(32'h500 + 32'(4 * k)));
            commit();
        end
        @(negedge clk);
        decoded_instr_valid_i = 1'b0;
        issue_ack_i           = 1'b0;
        flush_i               = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++; if (usage_o !== 0 || issue_instr_valid_o !== 1'b0 || issue_instr_prev_o !== '0) begin n_err++; $display("FAIL mid_reset: usage %0d valid %b prev %h want 0 0 0", usage_o, issue_instr_valid_o, issue_instr_prev_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        mq.delete();
        mprev = '0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_push_pop();
        test_flush();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
